// File: rtl/mux_pkg.sv
// Shared definitions for the N-input registered multiplexer pipeline:
// default parameter values, the beat layout and the select-width helper.
package mux_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_NUM_IN    = 4;
    localparam int DEF_ERR_CNT_W = 8;

    // One pipeline beat: the selected word plus its out-of-range flag.
    // Blocks with a non-default WIDTH declare the same layout at their width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 sel_err;
    } beat_t;

    // Select width for n inputs; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way select with range check. An index at or beyond NUM_IN
// yields all-zero data and raises sel_err.
module mux_n_sel
    import mux_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_IN = DEF_NUM_IN,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [WIDTH-1:0] in_data [NUM_IN],
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] data,
    output logic             sel_err
);

    // Compare sel against every legal index so an illegal one never indexes the array.
    always_comb begin
        // NOTE: both outputs get a default before any branch, so no path infers a latch.
        data    = '0;
        sel_err = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data    = in_data[i];
                sel_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-input multiplexer with a valid/ready interface. A main output
// register plus one skid entry give two beats of buffering, so in_ready is a
// pure register output with no path from out_ready. Illegal selects pass
// through as zero-data beats flagged with sel_err and are counted.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int NUM_IN    = DEF_NUM_IN,
    parameter  int ERR_CNT_W = DEF_ERR_CNT_W,
    localparam int SEL_W     = sel_width(NUM_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data [NUM_IN],
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_sel_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Same layout as mux_pkg::beat_t, sized by this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sel_err;
    } pipe_beat_t;

    pipe_beat_t           in_beat;
    pipe_beat_t           main_q, main_d;
    pipe_beat_t           skid_q, skid_d;
    logic                 main_valid_q, main_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 in_ready_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 accept;

    mux_n_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .in_data (in_data),
        .sel     (sel),
        .data    (in_beat.data),
        .sel_err (in_beat.sel_err)
    );

    assign accept = in_valid && in_ready_q;

    // Next-state for the two-entry buffer: flush empties both, a free or
    // draining main register refills from skid first (older beat), else from
    // the input; a stalled main register parks the incoming beat in skid.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    // Saturating count of accepted illegal selects; a flush does not undo it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && in_beat.sel_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State registers; in_ready follows the next skid state so it is ready
    // again in the same cycle the skid entry empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_data    = main_q.data;
    assign out_sel_err = main_q.sel_err;
    assign out_valid   = main_valid_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: a 4-input instance (all selects legal) and a
// 3-input instance (sel=3 illegal) share clock and reset. Each accepted beat
// is predicted into a per-instance queue and compared when it drains.
module tb_mux_n_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic        sel_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // 4-input instance
    logic [31:0] in_data4 [4];
    logic [1:0]  sel4;
    logic        in_valid4, in_ready4, flush4;
    logic [31:0] out_data4;
    logic        out_sel_err4, out_valid4, out_ready4;
    logic [7:0]  err_cnt4;

    // 3-input instance
    logic [31:0] in_data3 [3];
    logic [1:0]  sel3;
    logic        in_valid3, in_ready3, flush3;
    logic [31:0] out_data3;
    logic        out_sel_err3, out_valid3, out_ready3;
    logic [7:0]  err_cnt3;

    int   errors = 0;
    int   checks = 0;
    exp_t sb4[$];
    exp_t sb3[$];
    logic [7:0] exp_err3;

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .ERR_CNT_W(8)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data4),
        .sel         (sel4),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .flush       (flush4),
        .out_data    (out_data4),
        .out_sel_err (out_sel_err4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .err_cnt     (err_cnt4)
    );

    mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .ERR_CNT_W(8)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data3),
        .sel         (sel3),
        .in_valid    (in_valid3),
        .in_ready    (in_ready3),
        .flush       (flush3),
        .out_data    (out_data3),
        .out_sel_err (out_sel_err3),
        .out_valid   (out_valid3),
        .out_ready   (out_ready3),
        .err_cnt     (err_cnt3)
    );

    // Resolve this cycle's handshakes against the scoreboards, then advance
    // to 1 time unit past the next rising edge.
    task automatic step();
        exp_t e;
        if (out_valid4 && out_ready4) begin
            checks++;
            if (sb4.size() == 0) begin
                errors++;
                $display("FAIL dut4_out_order: got data=%h err=%b, required no beat (scoreboard empty)", out_data4, out_sel_err4);
            end else begin
                e = sb4.pop_front();
                if (out_data4 !== e.data || out_sel_err4 !== e.sel_err) begin
                    errors++;
                    $display("FAIL dut4_out_beat: got data=%h err=%b, required data=%h err=%b", out_data4, out_sel_err4, e.data, e.sel_err);
                end
            end
        end
        if (flush4) sb4.delete();
        else if (in_valid4 && in_ready4) begin
            e.data    = in_data4[sel4];
            e.sel_err = 1'b0;
            sb4.push_back(e);
        end

        if (out_valid3 && out_ready3) begin
            checks++;
            if (sb3.size() == 0) begin
                errors++;
                $display("FAIL dut3_out_order: got data=%h err=%b, required no beat (scoreboard empty)", out_data3, out_sel_err3);
            end else begin
                e = sb3.pop_front();
                if (out_data3 !== e.data || out_sel_err3 !== e.sel_err) begin
                    errors++;
                    $display("FAIL dut3_out_beat: got data=%h err=%b, required data=%h err=%b", out_data3, out_sel_err3, e.data, e.sel_err);
                end
            end
        end
        if (in_valid3 && in_ready3) begin
            if (sel3 < 2'd3) begin
                e.data    = in_data3[sel3];
                e.sel_err = 1'b0;
            end else begin
                e.data    = 32'h0;
                e.sel_err = 1'b1;
                if (exp_err3 != 8'hFF) exp_err3 = exp_err3 + 8'd1;
            end
            if (!flush3) sb3.push_back(e);
        end
        if (flush3) sb3.delete();

        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b0; sel4 = '0;
        in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0; sel3 = '0;
        in_data4 = '{32'h0, 32'h0, 32'h0, 32'h0};
        in_data3 = '{32'h0, 32'h0, 32'h0};
        exp_err3 = 8'd0;
        #12;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid4); end
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready4); end
        checks++; if (out_data4 !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h, required 0", out_data4); end
        checks++; if (out_sel_err4 !== 1'b0) begin errors++; $display("FAIL rst_sel_err: got %b, required 0", out_sel_err4); end
        checks++; if (err_cnt3 !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d, required 0", err_cnt3); end
        checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL rst_out_valid3: got %b, required 0", out_valid3); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL rst_release_no_edge: in_ready got %b, required 0", in_ready4); end
        @(posedge clk);
        #1;
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready: got %b, required 1", in_ready4); end
        checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready3: got %b, required 1", in_ready3); end
    endtask

    task automatic test_legal();
        in_data4   = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
        sel4       = 2'd2;
        in_valid4  = 1'b1;
        out_ready4 = 1'b1;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL legal_empty: out_valid got %b, required 0", out_valid4); end
        step();
        in_valid4 = 1'b0;
        checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL legal_latency: out_valid got %b, required 1", out_valid4); end
        checks++; if (out_data4 !== 32'hC2) begin errors++; $display("FAIL legal_data: got %h, required c2", out_data4); end
        checks++; if (out_sel_err4 !== 1'b0) begin errors++; $display("FAIL legal_sel_err: got %b, required 0", out_sel_err4); end
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL legal_drained: out_valid got %b, required 0", out_valid4); end
        for (int s = 0; s < 4; s++) begin
            sel4      = 2'(s);
            in_valid4 = 1'b1;
            step();
        end
        in_valid4 = 1'b0;
        step();
        checks++; if (sb4.size() != 0) begin errors++; $display("FAIL legal_all_sel_drained: %0d beats left, required 0", sb4.size()); end
        checks++; if (err_cnt4 !== 8'd0) begin errors++; $display("FAIL legal_err_cnt: got %0d, required 0", err_cnt4); end
    endtask

    task automatic test_illegal();
        in_data3   = '{32'h11, 32'h22, 32'h33};
        out_ready3 = 1'b1;
        sel3       = 2'd3;
        in_valid3  = 1'b1;
        checks++; if (err_cnt3 !== 8'd0) begin errors++; $display("FAIL illegal_cnt_start: got %0d, required 0", err_cnt3); end
        step();
        in_valid3 = 1'b0;
        checks++; if (out_data3 !== 32'h0) begin errors++; $display("FAIL illegal_data: got %h, required 0", out_data3); end
        checks++; if (out_sel_err3 !== 1'b1) begin errors++; $display("FAIL illegal_sel_err: got %b, required 1", out_sel_err3); end
        checks++; if (err_cnt3 !== 8'd1) begin errors++; $display("FAIL illegal_cnt_one: got %0d, required 1", err_cnt3); end
        step();
        sel3      = 2'd1;
        in_valid3 = 1'b1;
        step();
        in_valid3 = 1'b0;
        checks++; if (out_data3 !== 32'h22 || out_sel_err3 !== 1'b0) begin errors++; $display("FAIL legal_on_3in: got data=%h err=%b, required data=22 err=0", out_data3, out_sel_err3); end
        checks++; if (err_cnt3 !== 8'd1) begin errors++; $display("FAIL legal_no_count: got %0d, required 1", err_cnt3); end
        step();
        sel3      = 2'd3;
        in_valid3 = 1'b1;
        repeat (300) step();
        in_valid3 = 1'b0;
        step();
        checks++; if (err_cnt3 !== 8'hFF) begin errors++; $display("FAIL illegal_saturate: got %0d, required 255", err_cnt3); end
        checks++; if (sb3.size() != 0) begin errors++; $display("FAIL illegal_drained: %0d beats left, required 0", sb3.size()); end
    endtask

    task automatic test_backpressure();
        in_data4   = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        out_ready4 = 1'b0;
        sel4       = 2'd0;
        in_valid4  = 1'b1;
        step();
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp_ready_after_x: got %b, required 1", in_ready4); end
        sel4 = 2'd1;
        step();
        in_valid4 = 1'b0;
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_ready_after_y: got %b, required 0", in_ready4); end
        checks++; if (out_valid4 !== 1'b1 || out_data4 !== 32'h1111_0000) begin errors++; $display("FAIL bp_hold_x: got valid=%b data=%h, required valid=1 data=11110000", out_valid4, out_data4); end
        sel4      = 2'd2;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        checks++; if (out_data4 !== 32'h1111_0000 || in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_stall_stable: got data=%h ready=%b, required data=11110000 ready=0", out_data4, in_ready4); end
        out_ready4 = 1'b1;
        step();
        checks++; if (out_valid4 !== 1'b1 || out_data4 !== 32'h2222_0001) begin errors++; $display("FAIL bp_then_y: got valid=%b data=%h, required valid=1 data=22220001", out_valid4, out_data4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp_ready_again: got %b, required 1", in_ready4); end
        step();
        checks++; if (out_valid4 !== 1'b0 || sb4.size() != 0) begin errors++; $display("FAIL bp_drained: valid=%b left=%0d, required valid=0 left=0", out_valid4, sb4.size()); end
    endtask

    task automatic test_reset_mid();
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        sel4       = 2'd0;
        step();
        sel4 = 2'd1;
        step();
        in_valid4 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid4); end
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready4); end
        checks++; if (err_cnt3 !== 8'd0) begin errors++; $display("FAIL midrst_err_cnt: got %0d, required 0", err_cnt3); end
        checks++; if (out_data4 !== 32'h0) begin errors++; $display("FAIL midrst_out_data: got %h, required 0", out_data4); end
        sb4.delete();
        sb3.delete();
        exp_err3   = 8'd0;
        out_ready4 = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b, required 1", in_ready4); end
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_no_partial: out_valid got %b, required 0", out_valid4); end
    endtask

    task automatic test_flush();
        in_data3   = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002};
        out_ready3 = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 1'b1;
        step();
        sel3 = 2'd1;
        step();
        flush3 = 1'b1;
        sel3   = 2'd3;
        step();
        flush3    = 1'b0;
        in_valid3 = 1'b0;
        checks++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin errors++; $display("FAIL flush_full: got valid=%b ready=%b, required valid=0 ready=1", out_valid3, in_ready3); end
        checks++; if (err_cnt3 !== 8'd0) begin errors++; $display("FAIL flush_full_cnt: got %0d, required 0", err_cnt3); end
        sel3      = 2'd0;
        in_valid3 = 1'b1;
        step();
        flush3 = 1'b1;
        sel3   = 2'd3;
        step();
        flush3    = 1'b0;
        in_valid3 = 1'b0;
        checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL flush_drop_z: out_valid got %b, required 0", out_valid3); end
        checks++; if (err_cnt3 !== 8'd1) begin errors++; $display("FAIL flush_z_counted: got %0d, required 1", err_cnt3); end
        out_ready3 = 1'b1;
        sel3       = 2'd2;
        in_valid3  = 1'b1;
        step();
        in_valid3 = 1'b0;
        checks++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h5000_0002 || out_sel_err3 !== 1'b0) begin errors++; $display("FAIL flush_next_beat: got valid=%b data=%h err=%b, required valid=1 data=50000002 err=0", out_valid3, out_data3, out_sel_err3); end
        flush3 = 1'b1;
        step();
        flush3 = 1'b0;
        checks++; if (out_valid3 !== 1'b0 || sb3.size() != 0) begin errors++; $display("FAIL flush_drain_same_cycle: valid=%b left=%0d, required valid=0 left=0", out_valid3, sb3.size()); end
    endtask

    task automatic test_stream();
        int stalls = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid4  = ($urandom_range(0, 9) < 7);
            out_ready4 = ($urandom_range(0, 9) < 6);
            sel4       = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) in_data4[k] = $urandom;
            in_valid3  = ($urandom_range(0, 9) < 7);
            out_ready3 = ($urandom_range(0, 9) < 6);
            flush3     = ($urandom_range(0, 99) < 3);
            sel3       = 2'($urandom_range(0, 3));
            for (int k = 0; k < 3; k++) in_data3[k] = $urandom;
            step();
        end
        in_valid4 = 1'b0; in_valid3 = 1'b0; flush3 = 1'b0;
        out_ready4 = 1'b1; out_ready3 = 1'b1;
        repeat (4) step();
        checks++; if (sb4.size() != 0) begin errors++; $display("FAIL stream_loss4: %0d beats never emerged, required 0", sb4.size()); end
        checks++; if (sb3.size() != 0) begin errors++; $display("FAIL stream_loss3: %0d beats never emerged, required 0", sb3.size()); end
        checks++; if (err_cnt3 !== exp_err3) begin errors++; $display("FAIL stream_err_cnt: got %0d, required %0d", err_cnt3, exp_err3); end
        in_valid4 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            sel4 = 2'(c % 4);
            for (int k = 0; k < 4; k++) in_data4[k] = $urandom;
            if (in_ready4 !== 1'b1 || (c > 0 && out_valid4 !== 1'b1)) stalls++;
            step();
        end
        in_valid4 = 1'b0;
        step();
        checks++; if (stalls != 0) begin errors++; $display("FAIL full_throughput: %0d stalled cycles, required 0", stalls); end
        checks++; if (sb4.size() != 0) begin errors++; $display("FAIL throughput_drained: %0d beats left, required 0", sb4.size()); end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_flush();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NUM_IN, default 4, meaning number of data inputs (legal range 2..16).
REQ-003 SHALL have parameter ERR_CNT_W, default 8, meaning width of the illegal-select counter.
REQ-004 SHALL have derived localparam SEL_W = max(1, clog2(NUM_IN)).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-007 SHALL have port in_data, input, NUM_IN x WIDTH, meaning the unpacked array of candidate data words.
REQ-008 SHALL have port sel, input, SEL_W bits, meaning the index of the selected input.
REQ-009 SHALL have port in_valid, input, 1 bit, meaning in_data and sel are valid this cycle.
REQ-010 SHALL have port in_ready, output, 1 bit, meaning the block accepts a beat this cycle.
REQ-011 SHALL have port flush, input, 1 bit, meaning discard all buffered beats (pipeline flush).
REQ-012 SHALL have port out_data, output, WIDTH bits, meaning the registered selected word.
REQ-013 SHALL have port out_sel_err, output, 1 bit, meaning the out_data beat came from an out-of-range sel.
REQ-014 SHALL have port out_valid, output, 1 bit, meaning out_data and out_sel_err are valid.
REQ-015 SHALL have port out_ready, input, 1 bit, meaning the downstream stage accepts the beat.
REQ-016 SHALL have port err_cnt, output, ERR_CNT_W bits, meaning the saturating count of accepted illegal selects.

Function
REQ-017 SHALL transfer a beat in on in_valid && in_ready, and out on out_valid && out_ready.
REQ-018 SHALL select in_data[sel] when sel < NUM_IN; otherwise it SHALL select all-zero data with the beat's sel_err bit set to 1.
REQ-019 SHALL register the selection, so that an accepted beat appears on out_data no earlier than the next cycle (latency 1 with an empty pipeline).
REQ-020 SHALL hold a main output register plus a one-entry skid register; combined capacity SHALL be 2 beats.
REQ-021 SHALL drive in_ready = !skid_valid from a register only, with no combinational path from out_ready to in_ready.
REQ-022 SHALL, when the main register is empty or draining (out_ready=1), load an accepted beat into the main register; otherwise it SHALL load it into the skid register.
REQ-023 SHALL, when the main register drains and the skid register is full, move the skid contents to the main register in the same cycle.
REQ-024 SHALL keep out_data and out_sel_err stable while out_valid=1 and out_ready=0.
REQ-025 SHALL preserve beat order under every combination of in_valid and out_ready.
REQ-026 SHALL, on flush=1, clear both valid bits at the next edge; a beat presented in the same cycle SHALL be dropped, and a beat draining in the same cycle SHALL still count as transferred.
REQ-027 SHALL increment err_cnt by 1 on each accepted illegal-sel beat (including beats dropped by flush) and SHALL saturate at all-ones.
REQ-028 SHALL NOT clear err_cnt on flush.
REQ-029 SHALL NOT change state or outputs while in_valid=0, out_ready=0 and flush=0.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force out_valid=0, skid_valid=0, in_ready=0, out_data=0, out_sel_err=0 and err_cnt=0.
REQ-031 SHALL raise in_ready to 1 on the first rising clk edge after rst_n deasserts.
REQ-032 SHALL discard any beat in flight when reset asserts mid-transfer, with no partial output.

Structure
REQ-033 SHALL define the default WIDTH, NUM_IN and ERR_CNT_W values, and the beat struct {data, sel_err}, in shared package mux_pkg.
REQ-034 SHALL implement the combinational select/range check in one sub-module, mux_n_sel (in_data, sel -> data, sel_err), instantiated once.

Verification
REQ-035 SHALL cover legal selects: NUM_IN=4, in_data={A0,B1,C2,D3}, sel=2, out_ready=1 -> out_data=C2, out_valid=1 one cycle later, out_sel_err=0.
REQ-036 SHALL cover illegal selects: NUM_IN=3, sel=3 accepted -> out_data=0, out_sel_err=1, err_cnt 0->1; 300 such beats with ERR_CNT_W=8 -> err_cnt=255.
REQ-037 SHALL cover backpressure: out_ready=0 for 3 cycles while beats X then Y are sent -> in_ready=0 after Y, out_data=X held; out_ready=1 -> X then Y in order, in_ready=1 again.
REQ-038 SHALL cover flush: both registers full, flush=1 with in_valid=1 (beat Z) -> next cycle out_valid=0, Z never appears, err_cnt unchanged unless Z was illegal.
REQ-039 SHALL cover reset: rst_n low mid-stream asynchronously -> out_valid=0, err_cnt=0 before the next edge; in_ready=1 one edge after release.
REQ-040 SHALL cover streaming: random in_valid/out_ready for 10k cycles against a scoreboard -> no loss, duplication or reordering, and full throughput when out_ready=1.
